// File: rtl/output_credit_port.sv
// output_credit_port
//   Router output-port stage driving one inter-router channel straight into
//   the neighbour's input-queue FIFO. A credit counter mirrors the free slots
//   of that FIFO; a packet is admitted only when all of its flits fit
//   (virtual cut-through), and accepted flits leave through a single output
//   register, so each flit appears on the channel one cycle after it is accepted.
//
// Ports
//   clk               system clock
//   reset             synchronous, active-high reset
//   flit_valid_din    crossbar/arbiter presents a flit
//   flit_data_din     flit payload
//   credit_din        one pulse per flit read from the downstream FIFO
//   flit_ack_dout     flit accepted this cycle (combinational)
//   port_ready_dout   idle with credits for a whole packet (combinational)
//   write_strobe_dout registered write strobe to the downstream FIFO
//   channel_dout      registered flit to the downstream FIFO
//   credits_dout      current credit count
//   credit_error_dout sticky credit-overflow flag

`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 8
`endif
`ifndef BUFFER_DEPTH
`define BUFFER_DEPTH 8
`endif

module output_credit_port #(
   parameter int CHANNEL_WIDTH = `CHANNEL_WIDTH,
   parameter int BUFFER_DEPTH  = `BUFFER_DEPTH,
   parameter int PACKET_FLITS  = 4,
   localparam int CREDIT_WIDTH = $clog2(BUFFER_DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flit_valid_din,
   input  logic [CHANNEL_WIDTH-1:0] flit_data_din,
   input  logic                     credit_din,
   output logic                     flit_ack_dout,
   output logic                     port_ready_dout,
   output logic                     write_strobe_dout,
   output logic [CHANNEL_WIDTH-1:0] channel_dout,
   output logic [CREDIT_WIDTH-1:0]  credits_dout,
   output logic                     credit_error_dout
);

   localparam int CNT_W = (PACKET_FLITS > 1) ? $clog2(PACKET_FLITS) : 1;
   localparam logic [CREDIT_WIDTH-1:0] FULL_CREDITS = CREDIT_WIDTH'(BUFFER_DEPTH);
   localparam logic [CREDIT_WIDTH-1:0] PKT_CREDITS  = CREDIT_WIDTH'(PACKET_FLITS);
   localparam logic [CNT_W-1:0]        CNT_LOAD     = CNT_W'(PACKET_FLITS - 1);

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t                  state, state_next;
   logic [CNT_W-1:0]        flit_cnt, flit_cnt_next;
   logic [CREDIT_WIDTH-1:0] credits;
   logic                    accept;

   assign port_ready_dout = (state == IDLE) && (credits >= PKT_CREDITS) && !reset;
   assign accept          = flit_valid_din && !reset &&
                            (((state == IDLE) && port_ready_dout) || (state == SEND));
   assign flit_ack_dout   = accept;
   assign credits_dout    = credits;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         flit_cnt <= '0;
      end else begin
         state    <= state_next;
         flit_cnt <= flit_cnt_next;
      end
   end

   // flit_cnt holds the flits still owed after the current one; the accept
   // that takes it to zero is the packet's last flit and returns to IDLE.
   always_comb begin
      state_next    = state;
      flit_cnt_next = flit_cnt;
      unique case (state)
         IDLE: begin
            if (accept) begin
               flit_cnt_next = CNT_LOAD;
               if (PACKET_FLITS > 1) state_next = SEND;
            end
         end
         SEND: begin
            if (accept) begin
               flit_cnt_next = flit_cnt - 1'b1;
               if (flit_cnt == CNT_W'(1)) state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Credits were reserved at admission, so a decrement never sees zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         credits           <= FULL_CREDITS;
         credit_error_dout <= 1'b0;
      end else if (accept && !credit_din) begin
         credits <= credits - 1'b1;
      end else if (credit_din && !accept) begin
         if (credits == FULL_CREDITS) credit_error_dout <= 1'b1;
         else                         credits <= credits + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         write_strobe_dout <= 1'b0;
         channel_dout      <= '0;
      end else begin
         write_strobe_dout <= accept;
         if (accept) channel_dout <= flit_data_din;
      end
   end

endmodule
